// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: A - B as sign-magnitude, one digit per clock, LSD first.
// Adds the nines' complement of B with carry-in 1, then re-complements a negative result.

module bcd_nines_comp (
    input  logic [3:0] digit_i,
    output logic [3:0] comp_o
);
    assign comp_o = 4'd9 - digit_i;
endmodule

module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  neg,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, diff_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q, busy_q, done_q, neg_q, err_q;

    logic [3:0]      aDigit, bDigit, diffDigit, bComp, diffComp, digit_d;
    logic [4:0]      sum;
    logic            carry_d, inBad, lastDigit;

    assign aDigit    = a_q[{idx_q, 2'b00} +: 4];
    assign bDigit    = b_q[{idx_q, 2'b00} +: 4];
    assign diffDigit = diff_q[{idx_q, 2'b00} +: 4];
    assign lastDigit = (idx_q == IW'(DIGITS - 1));

    bcd_nines_comp uCompB    (.digit_i(bDigit),    .comp_o(bComp));
    bcd_nines_comp uCompDiff (.digit_i(diffDigit), .comp_o(diffComp));

    // FIX re-complements the stored digit; ADD sums A with complemented B.
    always_comb begin
        sum     = 5'd0;
        digit_d = 4'd0;
        carry_d = 1'b0;
        if (state_q == FIX)
            sum = {1'b0, diffComp} + {4'b0, carry_q};
        else
            sum = {1'b0, aDigit} + {1'b0, bComp} + {4'b0, carry_q};
        if (sum > 5'd9) begin
            digit_d = sum[3:0] + 4'd6;
            carry_d = 1'b1;
        end else begin
            digit_d = sum[3:0];
            carry_d = 1'b0;
        end
    end

    always_comb begin
        inBad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if ((a[4*k +: 4] > 4'd9) || (b[4*k +: 4] > 4'd9))
                inBad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        neg_q  <= 1'b0;
                        busy_q <= 1'b1;
                        idx_q  <= '0;
                        if (inBad) begin
                            err_q   <= 1'b1;
                            diff_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            carry_q <= 1'b1;
                            state_q <= ADD;
                        end
                    end
                end
                ADD: begin
                    diff_q[{idx_q, 2'b00} +: 4] <= digit_d;
                    idx_q   <= idx_q + 1'b1;
                    carry_q <= carry_d;
                    if (lastDigit) begin
                        if (carry_d) begin
                            neg_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // No carry out means A < B: diff holds the tens' complement.
                            neg_q   <= 1'b1;
                            carry_q <= 1'b1;
                            idx_q   <= '0;
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    diff_q[{idx_q, 2'b00} +: 4] <= digit_d;
                    idx_q   <= idx_q + 1'b1;
                    carry_q <= carry_d;
                    if (lastDigit) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule
